data_memory_mips_bhw: RTL

Parametrised MIPS data memory with byte/halfword/word load-store, sign/zero extension, a request/acknowledge handshake and programmable wait states. It sits on the CPU memory stage and supersedes the single-cycle word-only data memory. Accesses are byte-addressed and little-endian within a 32-bit word. Errors are reported with the acknowledge.

---
 rtl/data_memory_pkg.sv | 17 +
 rtl/data_memory_mips_bhw_load_store_align.sv | 52 +++++
 rtl/data_memory_mips_bhw.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared definitions for the byte/half/word MIPS data memory:
// access size codes, FSM state encoding and word geometry.
package data_memory_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/data_memory_mips_bhw_load_store_align.sv
// Combinational lane steering for little-endian byte/half/word accesses:
// store byte mask and lane data, load extraction/extension, misalignment flag.
module load_store_align
    import data_memory_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Sub-word sizes only look at the address bits they need, so the
    // offending low bits are effectively forced to zero here.
    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = 32'h0;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        byte_v     = 8'h0;
        half_v     = 16'h0;
        case (size_i)
            SIZE_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                byte_v  = rword_i[{addr_lo_i, 3'b000} +: 8];
                rdata_o = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SIZE_HALF: begin
                misalign_o = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                half_v     = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
                rdata_o    = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: begin
                misalign_o = (addr_lo_i != 2'b00);
                be_o       = 4'b1111;
                wdata_o    = wdata_i;
                rdata_o    = rword_i;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_mips_bhw.sv
// MIPS data memory with byte/half/word access, req/ack handshake and wait states.
// Define DATA_MEMORY_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module data_memory_mips_bhw
    import data_memory_pkg::*;
#(
    parameter int ADDR_BIT    = 31,
    parameter int MEMORY_SIZE = 2047,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    input  logic                in_req,
    input  logic                in_we,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [ADDR_BIT:0]   in_addr,
    input  logic [31:0]         in_write_data,
    output logic [31:0]         out_read_data,
    output logic                out_ack,
    output logic                out_busy,
    output logic                out_err
);

    localparam int         IDX_W     = ADDR_BIT - 1;
    localparam int         MEM_AW    = $clog2(MEMORY_SIZE + 1);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                exec;

    logic                we_q, uns_q;
    logic [1:0]          size_q;
    logic [ADDR_BIT:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;

    logic                acc_we, acc_uns;
    logic [1:0]          acc_size;
    logic [ADDR_BIT:0]   acc_addr;
    logic [31:0]         acc_wdata;
    logic [IDX_W-1:0]    widx;
    logic [MEM_AW-1:0]   mem_idx;
    logic                in_range, acc_err;
    logic [31:0]         rword, lane_wdata, ext_rdata;
    logic [3:0]          be;
    logic                misalign;

    logic [31:0] mem [0:MEMORY_SIZE];

    // With zero wait states the access executes on the sampling edge itself,
    // so the request inputs feed the datapath directly while in IDLE.
    assign acc_we    = (state_q == ST_IDLE) ? in_we         : we_q;
    assign acc_uns   = (state_q == ST_IDLE) ? in_unsigned   : uns_q;
    assign acc_size  = (state_q == ST_IDLE) ? in_size       : size_q;
    assign acc_addr  = (state_q == ST_IDLE) ? in_addr       : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? in_write_data : wdata_q;

    assign widx     = acc_addr[ADDR_BIT:2];
    assign mem_idx  = widx[MEM_AW-1:0];
    assign in_range = (64'(widx) <= 64'(MEMORY_SIZE));
    assign rword    = mem[mem_idx];

    load_store_align u_align (
        .size_i     (acc_size),
        .addr_lo_i  (acc_addr[1:0]),
        .unsigned_i (acc_uns),
        .wdata_i    (acc_wdata),
        .rword_i    (rword),
        .be_o       (be),
        .wdata_o    (lane_wdata),
        .rdata_o    (ext_rdata),
        .misalign_o (misalign)
    );

`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    assign acc_err = !in_range || misalign;
`else
    assign acc_err = !in_range;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_ACK;
                        exec    = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                    exec    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (exec) begin
                rdata_q <= acc_err ? 32'h0 : ext_rdata;
                err_q   <= acc_err;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (state_q == ST_IDLE && in_req) begin
            we_q    <= in_we;
            uns_q   <= in_unsigned;
            size_q  <= in_size;
            addr_q  <= in_addr;
            wdata_q <= in_write_data;
        end
    end

    // Reset wins over a pending access: an abandoned store never lands.
    always_ff @(posedge in_clk) begin
        if (exec && in_rst_n && acc_we && !acc_err) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) mem[mem_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
            end
        end
    end

    assign out_read_data = rdata_q;
    assign out_err       = err_q;
    assign out_ack       = (state_q == ST_ACK);
    assign out_busy      = (state_q != ST_IDLE);

endmodule
